// File: rtl/bch_bench_harness.sv
// bch_bench_harness: serial-load / run / serial-unload shell that XOR-folds DUT result words
// into a {1, timeout, gap, acc} status frame shifted out MSB first.
module bch_bench_harness #(
  parameter int IN_BITS       = 8,
  parameter int OUT_BITS      = 4,
  parameter int CAPTURE_WORDS = 4,
  parameter int TIMEOUT       = 255,
  parameter int IN_STAGES     = 2,
  parameter int OUT_STAGES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ser_en,
  input  logic                ser_in,
  output logic                ser_out,
  output logic                ser_busy,
  output logic [IN_BITS-1:0]  dut_in,
  output logic                dut_start,
  input  logic [OUT_BITS-1:0] dut_out,
  input  logic                dut_valid
);
  localparam int F  = OUT_BITS + 3;
  localparam int CB = $clog2(IN_BITS + 1);
  localparam int WB = $clog2(CAPTURE_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int UB = $clog2(F);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE, UNLOAD} state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  ld_q, ld_d;
  logic [CB-1:0]       cnt_q, cnt_d;
  logic [OUT_BITS-1:0] acc_q, acc_d;
  logic [WB-1:0]       words_q, words_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [UB-1:0]       ucnt_q, ucnt_d;
  logic                gap_q, gap_d, tmo_q, tmo_d;
  logic                done, pre, en_s, bit_s;
  logic [F-1:0]        frame;

  if (IN_STAGES > 0) begin : g_in
    logic [IN_STAGES:1] e_q, b_q;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        e_q <= '0;
        b_q <= '0;
      end else begin
        for (int k = IN_STAGES; k > 1; k--) begin
          e_q[k] <= e_q[k-1];
          b_q[k] <= b_q[k-1];
        end
        e_q[1] <= ser_en;
        b_q[1] <= ser_in;
      end
    assign en_s  = e_q[IN_STAGES];
    assign bit_s = b_q[IN_STAGES];
  end else begin : g_in0
    assign en_s  = ser_en;
    assign bit_s = ser_in;
  end

  if (OUT_STAGES > 0) begin : g_out
    logic [OUT_STAGES:1] o_q;
    always_ff @(posedge clk or posedge reset)
      if (reset) o_q <= '0;
      else begin
        for (int k = OUT_STAGES; k > 1; k--) o_q[k] <= o_q[k-1];
        o_q[1] <= pre;
      end
    assign ser_out = o_q[OUT_STAGES];
  end else begin : g_out0
    assign ser_out = pre;
  end

  assign frame     = {1'b1, tmo_q, gap_q, acc_q};
  assign dut_in    = ld_q;
  assign dut_start = state_q == START;
  assign ser_busy  = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    words_d = words_q;
    timer_d = timer_q;
    ucnt_d  = ucnt_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    done    = 1'b0;
    pre     = 1'b0;
    case (state_q)
      IDLE: if (en_s) begin
        ld_d    = {ld_q[IN_BITS-2:0], bit_s};
        cnt_d   = CB'(1);
        state_d = LOAD;
      end
      LOAD: if (en_s) begin
        ld_d    = {ld_q[IN_BITS-2:0], bit_s};
        cnt_d   = cnt_q + CB'(1);
        state_d = cnt_q == CB'(IN_BITS - 1) ? START : LOAD;
      end
      START: begin
        acc_d   = '0;
        words_d = '0;
        timer_d = '0;
        ucnt_d  = '0;
        gap_d   = 1'b0;
        tmo_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT, CAPTURE: begin
        timer_d = timer_q + TW'(1);
        if (dut_valid) begin
          acc_d   = acc_q ^ dut_out;
          words_d = words_q + WB'(1);
          done    = words_q == WB'(CAPTURE_WORDS - 1);
        end else if (state_q == CAPTURE) gap_d = 1'b1;
        // a word completing the run on the last allowed cycle beats the timeout
        if (done) state_d = UNLOAD;
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = UNLOAD;
        end else if (dut_valid) state_d = CAPTURE;
      end
      default: begin
        pre     = frame[UB'(F - 1) - ucnt_q];
        ucnt_d  = ucnt_q == UB'(F - 1) ? '0 : ucnt_q + UB'(1);
        state_d = ucnt_q == UB'(F - 1) ? IDLE : UNLOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ld_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      words_q <= '0;
      timer_q <= '0;
      ucnt_q  <= '0;
      gap_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      words_q <= words_d;
      timer_q <= timer_d;
      ucnt_q  <= ucnt_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
endmodule
